// File: rtl/data_mem_responder.sv
// Single-port word memory answering one request at a time after WAIT_CYCLES wait states.
// Define DMEM_BYTE_STROBE_EN to add the be_i byte-lane write strobe.
module data_mem_responder #(
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [3:0]  be_i,
`endif
  output logic        busy_o,
  output logic        ack_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] ADDR_LIM = 32'(DEPTH * 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_idle;
  logic        w_enter;
  logic        w_we;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic [31:0] w_mask;
  logic [31:0] w_wword;
  logic        w_err;
  logic [AW-1:0] w_idx;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      if (w_idle && req_i) begin
        r_we    <= we_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (req_i) begin
          if (WAIT_CYCLES == 0) begin
            w_next = S_RESP;
          end else begin
            w_next     = S_WAIT;
            w_cnt_next = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Zero wait states enter RESP straight from IDLE, so use live inputs there
  assign w_idle  = (r_state == S_IDLE);
  assign w_enter = (w_next == S_RESP) && (r_state != S_RESP);
  assign w_we    = w_idle ? we_i    : r_we;
  assign w_addr  = w_idle ? addr_i  : r_addr;
  assign w_wdata = w_idle ? wdata_i : r_wdata;
  assign w_idx   = w_addr[AW+1:2];
  assign w_err   = (w_addr[1:0] != 2'b00) || (w_addr >= ADDR_LIM);

`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0] r_be;
  logic [3:0] w_be;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_be <= '0;
    end else if (w_idle && req_i) begin
      r_be <= be_i;
    end
  end

  assign w_be   = w_idle ? be_i : r_be;
  assign w_mask = {{8{w_be[3]}}, {8{w_be[2]}},
                   {8{w_be[1]}}, {8{w_be[0]}}};
`else
  assign w_mask = '1;
`endif

  assign w_wword = (r_mem[w_idx] & ~w_mask) | (w_wdata & w_mask);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_enter && w_we && !w_err) begin
      r_mem[w_idx] <= w_wword;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (w_enter) begin
      r_err   <= w_err;
      r_rdata <= (w_we || w_err) ? 32'd0 : r_mem[w_idx];
    end
  end

  assign busy_o  = !w_idle;
  assign ack_o   = (r_state == S_RESP);
  assign rdata_o = r_rdata;
  assign err_o   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (WAIT_CYCLES=2 and WAIT_CYCLES=0 instances).
`timescale 1ns/1ps
module tb_data_mem_responder;

  localparam int DEPTH = 128;
  localparam int W     = 2;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req, we, busy, ack, err;
  logic [31:0] addr, wdata, rdata;
  logic        req0, we0, busy0, ack0, err0;
  logic [31:0] addr0, wdata0, rdata0;
`ifdef DMEM_BYTE_STROBE_EN
  logic [3:0]  be, be0;
`endif

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we),
    .addr_i(addr), .wdata_i(wdata),
`ifdef DMEM_BYTE_STROBE_EN
    .be_i(be),
`endif
    .busy_o(busy), .ack_o(ack), .rdata_o(rdata), .err_o(err)
  );

  data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .req_i(req0), .we_i(we0),
    .addr_i(addr0), .wdata_i(wdata0),
`ifdef DMEM_BYTE_STROBE_EN
    .be_i(be0),
`endif
    .busy_o(busy0), .ack_o(ack0), .rdata_o(rdata0), .err_o(err0)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mdl [DEPTH];
  int          cyc = 0;
  int          free_at = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_acks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: one transaction, applied in issue order
  function automatic exp_t model(input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] b,
                                 input int c);
    exp_t        e;
    logic [31:0] m;
    int          idx;
    logic        bad;
    bad = (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    idx = int'(a[AW+1:2]);
    m = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
    e.cyc = c + W + 1;
    e.err = bad;
    e.rdata = 32'd0;
    if (!bad) begin
      if (w) mdl[idx] = (mdl[idx] & ~m) | (d & m);
      else   e.rdata = mdl[idx];
    end
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'd0;
    q.delete();
    free_at = 0;
  endtask

  always @(negedge clk) begin
    if (!rst && ack) begin
      exp_t e;
      n_acks++;
      n_checks++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_ack: got ack at cycle %0d, required none", cyc);
      end else begin
        e = q.pop_front();
        if (cyc !== e.cyc) begin
          n_fail++;
          $display("FAIL ack_cycle: got %0d, required %0d", cyc, e.cyc);
        end
        n_checks++;
        if (rdata !== e.rdata) begin
          n_fail++;
          $display("FAIL ack_rdata: got %h, required %h", rdata, e.rdata);
        end
        n_checks++;
        if (err !== e.err) begin
          n_fail++;
          $display("FAIL ack_err: got %b, required %b", err, e.err);
        end
      end
    end
  end

  task automatic drive(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    @(negedge clk);
    req = 1'b1;
    we = w;
    addr = a;
    wdata = d;
`ifdef DMEM_BYTE_STROBE_EN
    be = b;
`endif
    if (cyc >= free_at) begin
      q.push_back(model(w, a, d, b, cyc));
      free_at = cyc + W + 2;
    end
  endtask

  task automatic wait_done(input string name);
    int k;
    @(negedge clk);
    req = 1'b0;
    k = 0;
    while ((q.size() != 0 || cyc < free_at) && k < 60) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending, required 0", name, q.size());
      q.delete();
    end
  endtask

  task automatic xact(input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] b,
                      input string name);
    drive(w, a, d, b);
    wait_done(name);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
`ifdef DMEM_BYTE_STROBE_EN
    be = 4'hF; be0 = 4'hF;
`endif
    model_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b, required 0", busy);
    end
    n_checks++;
    if (ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_ack: got %b, required 0", ack);
    end
    n_checks++;
    if (rdata !== 32'd0) begin
      n_fail++; $display("FAIL reset_rdata: got %h, required 0", rdata);
    end
    n_checks++;
    if (err !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL reset_err: got %b/%b, required 0/0", err, busy0);
    end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10");
    xact(1'b0, 32'h10, 32'h0, 4'hF, "rd10");
    n_checks++;
    if (rdata !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL rdata_hold: got %h, required deadbeef", rdata);
    end
  endtask

  task automatic test_errors();
    xact(1'b0, 32'h13, 32'h0, 4'hF, "rd13");
    xact(1'b0, 32'h200, 32'h0, 4'hF, "rd200");
    xact(1'b1, 32'h12, 32'h11111111, 4'hF, "wr12");
    xact(1'b1, 32'h200, 32'h22222222, 4'hF, "wr200");
    n_checks++;
    if (err !== 1'b1) begin
      n_fail++; $display("FAIL err_hold: got %b, required 1", err);
    end
    xact(1'b0, 32'h10, 32'h0, 4'hF, "rd10b");
    xact(1'b1, 32'h1FC, 32'hCAFEF00D, 4'hF, "wr1fc");
    xact(1'b0, 32'h1FC, 32'h0, 4'hF, "rd1fc");
    xact(1'b0, 32'h0, 32'h0, 4'hF, "rd0");
  endtask

  task automatic test_back_to_back();
    int a0;
    a0 = n_acks;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h40 + 32'(4 * i), 32'hA000_0000 + 32'(i), 4'hF);
    end
    wait_done("b2b");
    n_checks++;
    if (n_acks - a0 !== 3) begin
      n_fail++; $display("FAIL b2b_ack_count: got %0d, required 3", n_acks - a0);
    end
    xact(1'b0, 32'h40, 32'h0, 4'hF, "rd40");
    xact(1'b0, 32'h44, 32'h0, 4'hF, "rd44");
    xact(1'b0, 32'h50, 32'h0, 4'hF, "rd50");
    xact(1'b0, 32'h60, 32'h0, 4'hF, "rd60");
  endtask

  task automatic test_reset_abort();
    int a0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678;
`ifdef DMEM_BYTE_STROBE_EN
    be = 4'hF;
`endif
    @(negedge clk);
    req = 1'b0;
    a0 = n_acks;
    rst = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_async_busy: got %b, required 0", busy);
    end
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (n_acks !== a0) begin
      n_fail++; $display("FAIL abort_ack: got %0d acks, required 0", n_acks - a0);
    end
    xact(1'b0, 32'h20, 32'h0, 4'hF, "rd20");
    xact(1'b0, 32'h10, 32'h0, 4'hF, "rd10c");
  endtask

  task automatic test_zero_wait();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 32'h4; wdata0 = 32'hA5A5A5A5;
    @(negedge clk);
    req0 = 1'b0;
    n_checks++;
    if (ack0 !== 1'b1 || busy0 !== 1'b1 || err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL zw_wr_ack: got ack/busy/err %b%b%b, required 110", ack0, busy0, err0);
    end
    @(negedge clk);
    n_checks++;
    if (ack0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL zw_idle: got ack/busy %b%b, required 00", ack0, busy0);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 32'h4;
    @(negedge clk);
    req0 = 1'b0;
    n_checks++;
    if (ack0 !== 1'b1 || busy0 !== 1'b1 || rdata0 !== 32'hA5A5A5A5) begin
      n_fail++;
      $display("FAIL zw_rd: got ack/busy %b%b data %h, required 11 a5a5a5a5", ack0, busy0, rdata0);
    end
    @(negedge clk);
    n_checks++;
    if (ack0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++; $display("FAIL zw_rd_idle: got ack/busy %b%b, required 00", ack0, busy0);
    end
  endtask

  task automatic test_byte_strobe();
`ifdef DMEM_BYTE_STROBE_EN
    xact(1'b1, 32'h0, 32'hFFFFFFFF, 4'hF, "be_full");
    xact(1'b1, 32'h0, 32'h00000000, 4'b0101, "be_0101");
    xact(1'b0, 32'h0, 32'h0, 4'hF, "be_rd");
    n_checks++;
    if (rdata !== 32'hFF00FF00) begin
      n_fail++; $display("FAIL be_merge: got %h, required ff00ff00", rdata);
    end
    xact(1'b1, 32'h0, 32'h12345678, 4'b0000, "be_none");
    xact(1'b0, 32'h0, 32'h0, 4'hF, "be_rd2");
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_errors();
    test_back_to_back();
    test_reset_abort();
    test_zero_wait();
    test_byte_strobe();
    repeat (4) @(negedge clk);
    n_checks++;
    if (q.size() != 0) begin
      n_fail++; $display("FAIL final_queue: got %0d, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
